// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the TinyMIPS memory responder.
package mips_mem_pkg;

   localparam int unsigned DEF_WIDTH  = 8;
   localparam int unsigned DEF_ADDR_W = 8;
   // Wait counter width; covers WAIT_CYCLES up to 15.
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/mem_array.sv
// Byte storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so preloaded programs survive reset.
module mem_array
   import mips_mem_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Synchronous write port.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Wait-state memory responder for the multicycle TinyMIPS memory port,
// with a side-band preload port usable only while the bus is idle.
module mips_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] adr,
   input  logic [WIDTH-1:0]  writedata,
   input  logic              memread,
   input  logic              memwrite,
   output logic [WIDTH-1:0]  memdata,
   output logic              ready,
   output logic              busy,
   output logic              err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_adr,
   input  logic [WIDTH-1:0]  ld_data
);

   // Zero wait states skips WAIT and goes IDLE -> RESP directly.
   localparam bit              NO_WAIT  = (WAIT_CYCLES == 0);
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_adr;
   logic [WIDTH-1:0]  r_wdata;
   logic              r_write;

   logic              w_idle;
   logic              w_req_one;
   logic              w_req_both;
   logic              w_accept;
   logic              w_enter_resp;
   logic              w_cur_write;
   logic [ADDR_W-1:0] w_cur_adr;
   logic [WIDTH-1:0]  w_cur_wdata;
   logic              w_fsm_we;
   logic              w_ld_we;
   logic              w_err_set;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_waddr;
   logic [WIDTH-1:0]  w_mem_wdata;
   logic [WIDTH-1:0]  w_mem_rdata;

   // Request decode in IDLE.
   assign w_idle     = (r_state == ST_IDLE);
   assign w_req_one  = memread ^ memwrite;
   assign w_req_both = memread & memwrite;
   assign w_accept   = w_idle & w_req_one;

   // The edge that enters RESP performs the array access.
   assign w_enter_resp = ((r_state == ST_WAIT) && (r_cnt == '0)) ||
                         (w_accept && NO_WAIT);

   // With no wait states the access happens on the accept edge, so the
   // live bus is used instead of the latched copy.
   assign w_cur_write = w_idle ? memwrite  : r_write;
   assign w_cur_adr   = w_idle ? adr       : r_adr;
   assign w_cur_wdata = w_idle ? writedata : r_wdata;

   assign w_fsm_we  = w_enter_resp & w_cur_write;
   assign w_ld_we   = w_idle & ~memread & ~memwrite & ld_en;
   assign w_err_set = (w_idle & w_req_both) | (~w_idle & ld_en);

   // Single write port shared by the FSM and the preload port; they are
   // mutually exclusive because preload requires an idle, request-free bus.
   assign w_mem_we    = w_fsm_we | w_ld_we;
   assign w_mem_waddr = w_fsm_we ? w_cur_adr   : ld_adr;
   assign w_mem_wdata = w_fsm_we ? w_cur_wdata : ld_data;

   mem_array #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_mem_array (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (w_mem_waddr),
      .i_wdata (w_mem_wdata),
      .i_raddr (w_cur_adr),
      .o_rdata (w_mem_rdata)
   );

   // Control FSM, wait counter, request latches and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_adr   <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
         memdata <= '0;
         ready   <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         ready <= 1'b0;
         err   <= w_err_set;

         if (w_enter_resp && !w_cur_write) begin
            memdata <= w_mem_rdata;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_adr   <= adr;
                  r_wdata <= writedata;
                  r_write <= memwrite;
                  busy    <= 1'b1;
                  if (NO_WAIT) begin
                     r_state <= ST_RESP;
                     ready   <= 1'b1;
                  end else begin
                     r_state <= ST_WAIT;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= ST_RESP;
                  ready   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench: one responder with two wait states and
// one with none, checked against a transaction-level memory model.
module tb_mips_mem_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] adr       [2];
   logic [7:0] writedata [2];
   logic       memread   [2];
   logic       memwrite  [2];
   logic [7:0] memdata   [2];
   logic       ready     [2];
   logic       busy      [2];
   logic       err       [2];
   logic       ld_en     [2];
   logic [7:0] ld_adr    [2];
   logic [7:0] ld_data   [2];

   // Reference model: byte contents and last read value per instance.
   logic [7:0] m_mem [2][256];
   logic [7:0] m_rd  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_mem_responder #(.WIDTH(8), .ADDR_W(8), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .reset(reset), .adr(adr[0]), .writedata(writedata[0]),
      .memread(memread[0]), .memwrite(memwrite[0]), .memdata(memdata[0]),
      .ready(ready[0]), .busy(busy[0]), .err(err[0]), .ld_en(ld_en[0]),
      .ld_adr(ld_adr[0]), .ld_data(ld_data[0])
   );

   mips_mem_responder #(.WIDTH(8), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .reset(reset), .adr(adr[1]), .writedata(writedata[1]),
      .memread(memread[1]), .memwrite(memwrite[1]), .memdata(memdata[1]),
      .ready(ready[1]), .busy(busy[1]), .err(err[1]), .ld_en(ld_en[1]),
      .ld_adr(ld_adr[1]), .ld_data(ld_data[1])
   );

   function automatic int unsigned wc(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // All tasks start and end just after a rising edge.
   task automatic load(input int k, input logic [7:0] a, input logic [7:0] d);
      ld_en[k] = 1'b1; ld_adr[k] = a; ld_data[k] = d;
      @(posedge clk); #1;
      ld_en[k] = 1'b0;
      m_mem[k][a] = d;
      @(negedge clk);
      check("ld_err", 32'(err[k]), 32'd0);
      @(posedge clk); #1;
   endtask

   // One bus access; optionally drops the request after cycle 0 and
   // optionally strobes the preload port while busy.
   task automatic access(input int k, input bit wr, input logic [7:0] a,
                         input logic [7:0] d, input bit hold, input bit ldb);
      bit seen;
      int lat;
      seen = 1'b0;
      lat  = 0;
      adr[k] = a; writedata[k] = d; memread[k] = !wr; memwrite[k] = wr;
      @(negedge clk);
      check("busy_c0", 32'(busy[k]), 32'd0);
      @(posedge clk); #1;
      if (!hold) begin
         memread[k] = 1'b0; memwrite[k] = 1'b0;
         adr[k] = 8'($urandom); writedata[k] = 8'($urandom);
      end
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(negedge clk);
         check("busy", 32'(busy[k]), 32'd1);
         check("err", 32'(err[k]), 32'(ldb && n == 2));
         if (ldb && n == 1) begin
            ld_en[k] = 1'b1; ld_adr[k] = 8'($urandom); ld_data[k] = 8'($urandom);
         end
         if (ready[k]) begin
            seen = 1'b1;
            lat  = n;
         end else begin
            @(posedge clk); #1;
            ld_en[k] = 1'b0;
         end
      end
      check("timeout", 32'(seen), 32'd1);
      check("latency", 32'(lat), 32'(wc(k) + 1));
      if (wr) m_mem[k][a] = d;
      else    m_rd[k] = m_mem[k][a];
      check("memdata", 32'(memdata[k]), 32'(m_rd[k]));
      @(posedge clk); #1;
      memread[k] = 1'b0; memwrite[k] = 1'b0; ld_en[k] = 1'b0;
      @(negedge clk);
      check("ready_pulse", 32'(ready[k]), 32'd0);
      check("busy_idle", 32'(busy[k]), 32'd0);
      check("err_after", 32'(err[k]), 32'(ldb && lat == 1));
      @(posedge clk); #1;
   endtask

   // Both requests together: error pulse, no access, preload ignored.
   task automatic both(input int k, input logic [7:0] a);
      adr[k] = a; writedata[k] = ~m_mem[k][a];
      memread[k] = 1'b1; memwrite[k] = 1'b1;
      ld_en[k] = 1'b1; ld_adr[k] = a; ld_data[k] = ~m_mem[k][a];
      @(posedge clk); #1;
      memread[k] = 1'b0; memwrite[k] = 1'b0; ld_en[k] = 1'b0;
      @(negedge clk);
      check("both_err", 32'(err[k]), 32'd1);
      check("both_ready", 32'(ready[k]), 32'd0);
      check("both_busy", 32'(busy[k]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("both_err_end", 32'(err[k]), 32'd0);
      check("both_ready_end", 32'(ready[k]), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < 2; k++) begin
         check({tag, "_memdata"}, 32'(memdata[k]), 32'd0);
         check({tag, "_ready"},   32'(ready[k]),   32'd0);
         check({tag, "_busy"},    32'(busy[k]),    32'd0);
         check({tag, "_err"},     32'(err[k]),     32'd0);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_pulse");
      @(posedge clk); #1;
      reset = 1'b1;
      m_rd[0] = 8'h00; m_rd[1] = 8'h00;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired @%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] picks [4];
      picks[0] = 8'h00; picks[1] = 8'hFF; picks[2] = 8'h3C; picks[3] = 8'h80;
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         adr[k] = '0; writedata[k] = '0; memread[k] = 1'b0; memwrite[k] = 1'b0;
         ld_en[k] = 1'b0; ld_adr[k] = '0; ld_data[k] = '0; m_rd[k] = '0;
      end

      // Outputs held at zero while in reset.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Fill both arrays so the model is fully defined.
      for (int a = 0; a < 256; a++) begin
         for (int k = 0; k < 2; k++) load(k, 8'(a), 8'($urandom));
      end

      // Array survives reset.
      load(0, 8'h10, 8'h5A);
      load(1, 8'h10, 8'h5A);
      pulse_reset();
      access(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
      access(1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);

      // Basic read with two wait states.
      load(0, 8'h3C, 8'hA5);
      access(0, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0);

      // Write then read at the top address; bottom address unaffected.
      access(0, 1'b1, 8'hFF, 8'h7E, 1'b0, 1'b0);
      access(0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
      access(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

      // Both requests high, then confirm the target byte is unchanged.
      both(0, 8'h44);
      access(0, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0);
      both(1, 8'h45);
      access(1, 1'b0, 8'h45, 8'h00, 1'b0, 1'b0);

      // Zero wait states: back-to-back held reads, preload during RESP.
      memread[1] = 1'b1; adr[1] = 8'h01;
      @(negedge clk);
      check("b2b_c0_busy", 32'(busy[1]), 32'd0);
      @(posedge clk); #1;
      adr[1] = 8'h02;
      @(negedge clk);
      check("b2b_c1_ready", 32'(ready[1]), 32'd1);
      check("b2b_c1_data", 32'(memdata[1]), 32'(m_mem[1][1]));
      @(posedge clk); #1;
      @(negedge clk);
      check("b2b_c2_ready", 32'(ready[1]), 32'd0);
      check("b2b_c2_busy", 32'(busy[1]), 32'd0);
      @(posedge clk); #1;
      memread[1] = 1'b0;
      ld_en[1] = 1'b1; ld_adr[1] = 8'h02; ld_data[1] = ~m_mem[1][2];
      @(negedge clk);
      check("b2b_c3_ready", 32'(ready[1]), 32'd1);
      check("b2b_c3_busy", 32'(busy[1]), 32'd1);
      check("b2b_c3_data", 32'(memdata[1]), 32'(m_mem[1][2]));
      @(posedge clk); #1;
      ld_en[1] = 1'b0;
      m_rd[1] = m_mem[1][2];
      @(negedge clk);
      check("b2b_c4_err", 32'(err[1]), 32'd1);
      check("b2b_c4_ready", 32'(ready[1]), 32'd0);
      @(posedge clk); #1;
      access(1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0);

      // Reset during the wait of a write: nothing committed.
      load(0, 8'h20, 8'hC3);
      memwrite[0] = 1'b1; adr[0] = 8'h20; writedata[0] = 8'h11;
      @(posedge clk); #1;
      memwrite[0] = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_ready", 32'(ready[0]), 32'd0);
      check("midrst_memdata", 32'(memdata[0]), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      m_rd[0] = 8'h00; m_rd[1] = 8'h00;
      @(negedge clk);
      check("midrst_idle", 32'(busy[0]), 32'd0);
      @(posedge clk); #1;
      access(0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);

      // Randomized mix of operations on both instances.
      for (int i = 0; i < 300; i++) begin
         int         k;
         int         op;
         logic [7:0] a;
         k  = int'($urandom_range(1, 0));
         op = int'($urandom_range(9, 0));
         a  = ($urandom_range(1, 0) == 0) ? 8'($urandom) : picks[$urandom_range(3, 0)];
         case (op)
            0, 1, 2, 3: access(k, 1'b0, a, 8'h00, 1'($urandom), 1'b0);
            4, 5, 6:    access(k, 1'b1, a, 8'($urandom), 1'($urandom), 1'b0);
            7:          load(k, a, 8'($urandom));
            8:          both(k, a);
            default:    access(k, 1'b0, a, 8'h00, 1'($urandom), 1'b1);
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
